relu_act_stream: RTL

RELU_ACT_STREAM -- requirements
Module: relu_act_stream

---
 rtl/relu_pkg.sv | 13 +
 rtl/relu_lane.sv | 40 ++++
 rtl/relu_act_stream.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/relu_pkg.sv
// Shared activation-mode encoding for the ReLU activation stream.
package relu_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_CLAMP  = 2'd2,
        MODE_LEAKY  = 2'd3
    } mode_e;

endpackage

// File: rtl/relu_lane.sv
// Single-lane combinational activation: bypass, relu, clamped relu or leaky relu.
module relu_lane
    import relu_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 16,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned CLAMP_MAX  = 1536
) (
    input  mode_e                      mode_i,
    input  logic signed [BITWIDTH-1:0] x_i,
    output logic signed [BITWIDTH-1:0] y_c
);

    localparam logic signed [BITWIDTH-1:0] CLAMP_V = $signed(BITWIDTH'(CLAMP_MAX));

    logic is_neg;
    assign is_neg = x_i[BITWIDTH-1];

    always_comb begin
        y_c = x_i;
        case (mode_i)
            MODE_RELU: begin
                if (is_neg) y_c = '0;
            end
            MODE_CLAMP: begin
                if (is_neg) begin
                    y_c = '0;
                end else if (x_i > CLAMP_V) begin
                    y_c = CLAMP_V;
                end
            end
            // Arithmetic shift floors toward minus infinity, so -1 stays -1.
            MODE_LEAKY: begin
                if (is_neg) y_c = x_i >>> LEAK_SHIFT;
            end
            default: y_c = x_i;
        endcase
    end

endmodule

// File: rtl/relu_act_stream.sv
// Two-stage valid/ready activation pipeline with per-frame mode capture and
// a per-frame count of negative input elements.
module relu_act_stream
    import relu_pkg::*;
#(
    parameter int unsigned BITWIDTH    = 16,
    parameter int unsigned LANES       = 4,
    parameter int unsigned FRAME_BEATS = 49,
    parameter int unsigned LEAK_SHIFT  = 3,
    parameter int unsigned CLAMP_MAX   = 1536
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [MODE_W-1:0]                         mode,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BITWIDTH*LANES-1:0]                 in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [BITWIDTH*LANES-1:0]                 out_data,
    output logic                                      out_last,
    output logic [$clog2(FRAME_BEATS*LANES+1)-1:0]    neg_count,
    output logic                                      neg_count_valid
);

    localparam int unsigned DW     = BITWIDTH * LANES;
    localparam int unsigned CNT_W  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int unsigned NEG_W  = $clog2(FRAME_BEATS * LANES + 1);
    localparam int unsigned LNEG_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    mode_e             mode_cap_q, mode_cap_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DW-1:0]     s1_data_q, s1_data_d;
    mode_e             s1_mode_q, s1_mode_d;
    logic              s1_last_q, s1_last_d;
    logic [LNEG_W-1:0] s1_neg_q, s1_neg_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [NEG_W-1:0]  acc_q, acc_d;
    logic [NEG_W-1:0]  neg_count_q, neg_count_d;
    logic              ncv_q, ncv_d;

    logic              en1, en2, in_xfer;
    mode_e             beat_mode;
    logic [LNEG_W-1:0] in_neg;
    logic [DW-1:0]     act_data;

    // Stage 2 advances when empty or draining; stage 1 whenever stage 2 can take it.
    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;
    assign in_xfer  = in_valid && en1;

    // The first beat of a frame uses the live mode; the rest use the captured one.
    assign beat_mode = (beat_cnt_q == '0) ? mode_e'(mode) : mode_cap_q;

    always_comb begin
        in_neg = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            in_neg = in_neg + LNEG_W'(in_data[n*BITWIDTH + BITWIDTH - 1]);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        relu_lane #(
            .BITWIDTH  (BITWIDTH),
            .LEAK_SHIFT(LEAK_SHIFT),
            .CLAMP_MAX (CLAMP_MAX)
        ) u_lane (
            .mode_i(s1_mode_q),
            .x_i   (s1_data_q[g*BITWIDTH +: BITWIDTH]),
            .y_c   (act_data[g*BITWIDTH +: BITWIDTH])
        );
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        mode_cap_d  = mode_cap_q;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        s1_last_d   = s1_last_q;
        s1_neg_d    = s1_neg_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        acc_d       = acc_q;
        neg_count_d = neg_count_q;
        ncv_d       = 1'b0;

        if (in_xfer) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == '0) mode_cap_d = mode_e'(mode);
        end

        if (en1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = beat_mode;
                s1_last_d = (beat_cnt_q == LAST_BEAT);
                s1_neg_d  = in_neg;
            end
        end

        // Frame negative count is finalised as the last beat moves into stage 2.
        if (en2) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_data_d = act_data;
                if (s1_last_q) begin
                    neg_count_d = acc_q + NEG_W'(s1_neg_q);
                    acc_d       = '0;
                    ncv_d       = 1'b1;
                end else begin
                    acc_d = acc_q + NEG_W'(s1_neg_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            mode_cap_q  <= MODE_BYPASS;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= MODE_BYPASS;
            s1_last_q   <= 1'b0;
            s1_neg_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
            neg_count_q <= '0;
            ncv_q       <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            mode_cap_q  <= mode_cap_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            s1_last_q   <= s1_last_d;
            s1_neg_q    <= s1_neg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            acc_q       <= acc_d;
            neg_count_q <= neg_count_d;
            ncv_q       <= ncv_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_last        = out_last_q;
    assign neg_count       = neg_count_q;
    assign neg_count_valid = ncv_q;

endmodule
